// File: rtl/idp_sequencer.sv
// Instruction-decode sequencer: walks each accepted command through
// READ -> EXEC (EXEC_WAIT cycles) -> WB and drives the datapath controls.
// An illegal opcode is swallowed in IDLE and reported with a one-cycle err.
module idp_sequencer #(
    parameter int EXEC_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [4:0] cmd_fs,
    input  logic [4:0] cmd_s,
    input  logic [4:0] cmd_t,
    input  logic [4:0] cmd_d,
    input  logic [4:0] cmd_shamt,
    output logic [4:0] S_Addr,
    output logic [4:0] T_Addr,
    output logic [4:0] D_Addr,
    output logic [4:0] FS,
    output logic [4:0] shift_val,
    output logic       D_En,
    output logic       T_Sel,
    output logic       HILO_LD,
    output logic       S_sel,
    output logic [2:0] Y_Sel,
    output logic [1:0] DA_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] OP_ALU_RR = 3'd0;
    localparam logic [2:0] OP_ALU_RI = 3'd1;
    localparam logic [2:0] OP_MULDIV = 3'd2;
    localparam logic [2:0] OP_MFHI   = 3'd3;
    localparam logic [2:0] OP_MFLO   = 3'd4;
    localparam logic [2:0] OP_LINK   = 3'd5;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_WAIT - 1);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       rdy_en;      // low until the first edge after reset release
    logic [2:0] op_q;
    logic [4:0] fs_q, s_q, t_q, d_q, sh_q;
    logic       accept, cmd_legal, last_exec;

    assign cmd_ready = rdy_en && (state == IDLE || state == WB);
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_legal = (cmd_op <= OP_LINK);
    assign last_exec = (state == EXEC) && (cnt == EXEC_LAST);

    // Next-state: illegal opcodes are accepted but never leave IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && cmd_legal) state_nxt = READ;
            READ: state_nxt = EXEC;
            EXEC: if (last_exec) state_nxt = WB;
            WB:   state_nxt = (accept && cmd_legal) ? READ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, EXEC cycle counter, ready enable and error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            rdy_en <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            err    <= accept && !cmd_legal;
            if (state == EXEC && !last_exec) cnt <= cnt + 4'd1;
            else                             cnt <= 4'd0;
        end
    end

    // Command fields are captured on every accept, illegal ones included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= 3'd0;
            fs_q <= 5'd0;
            s_q  <= 5'd0;
            t_q  <= 5'd0;
            d_q  <= 5'd0;
            sh_q <= 5'd0;
        end else if (accept) begin
            op_q <= cmd_op;
            fs_q <= cmd_fs;
            s_q  <= cmd_s;
            t_q  <= cmd_t;
            d_q  <= cmd_d;
            sh_q <= cmd_shamt;
        end
    end

    assign S_Addr = s_q;
    assign T_Addr = t_q;
    assign D_Addr = d_q;
    assign S_sel  = 1'b0;

    // Per-state datapath controls; everything idles at zero.
    always_comb begin
        FS        = 5'd0;
        shift_val = 5'd0;
        D_En      = 1'b0;
        T_Sel     = 1'b0;
        HILO_LD   = 1'b0;
        Y_Sel     = 3'b000;
        DA_sel    = 2'b00;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            READ: T_Sel = (op_q == OP_ALU_RI);
            EXEC: begin
                FS        = fs_q;
                shift_val = sh_q;
                // HI/LO written at the end of EXEC so an MFHI/MFLO accepted
                // in this command's WB sees the fresh value without a stall.
                HILO_LD   = last_exec && (op_q == OP_MULDIV);
            end
            WB: begin
                done = 1'b1;
                case (op_q)
                    OP_ALU_RR: D_En = 1'b1;
                    OP_ALU_RI: begin D_En = 1'b1; DA_sel = 2'b01; end
                    OP_MFHI:   begin D_En = 1'b1; Y_Sel  = 3'b001; end
                    OP_MFLO:   begin D_En = 1'b1; Y_Sel  = 3'b010; end
                    OP_LINK:   begin D_En = 1'b1; Y_Sel  = 3'b100; DA_sel = 2'b10; end
                    default:   D_En = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule
